sr_latch_monitor: RTL and testbench
===================================

Name: sr_latch_monitor

Overview:
- Clocked observer on the far end of an active-high NOR SR latch interface: samples the latch inputs (S, R) and outputs (Q, Qn), tracks the expected latch state, and flags protocol violations.
- Detects the forbidden input S=R=1, the indeterminate 11->00 release race, output mismatches and output oscillation; keeps saturating event counters.
- Sits beside any sr_latch instance, in simulation benches or silicon debug logic, so that indeterminate cases are reported instead of hanging analysis.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on each of s_in/r_in/q_in/qn_in (minimum 2).
- SETTLE, 2, cycles the synchronised S/R must stay stable before outputs are checked (1..15).
- OSC_LIMIT, 4, Q toggles under stable S/R that declare oscillation (2..15).
- CNT_W, 8, width of each event counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_in  in  1  latch S, asynchronous.
- r_in  in  1  latch R, asynchronous.
- q_in  in  1  latch Q, asynchronous.
- qn_in  in  1  latch Qn, asynchronous.
- clear  in  1  synchronous clear of the counters and sticky flags.
- state  out  2  expected state: 0 UNK, 1 SET, 2 RST, 3 FORB.
- expected_q  out  1  1 in SET, 0 otherwise.
- forbidden  out  1  level: state==FORB.
- race  out  1  one-cycle pulse on FORB->UNK.
- mismatch  out  1  level: latch outputs disagree with the check for the current state.
- osc  out  1  sticky oscillation flag.
- forbid_cnt  out  CNT_W  entries into FORB.
- race_cnt  out  CNT_W  race pulses.
- mismatch_cnt  out  CNT_W  rising edges of mismatch.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops 0; state=UNK; expected_q, race, mismatch and osc = 0; counters 0; settle counter 0.
- Synchronisation: each input passes through SYNC_STAGES flops. The values s, r, q and qn below are the last-stage outputs.
- FSM (evaluated every clk, state registered; state changes one cycle after the synchronised S/R changes):
  - {s,r}=10 -> SET; 01 -> RST; 11 -> FORB.
  - {s,r}=00: hold the current state. Exception: FORB -> UNK with race=1 for exactly that cycle.
  - FORB exited via 10 or 01 goes to SET or RST with no race.
  - UNK is left only by 10, 01 or 11.
- Settle counter:
  - Cleared whenever {s,r} differs from its previous-cycle value; otherwise increments, saturating at SETTLE.
  - Checks are enabled only while the counter equals SETTLE.
- Check per state, when enabled; mismatch=1 if violated, else 0. mismatch is forced 0 while checks are disabled.
  - SET: q=1, qn=0.
  - RST: q=0, qn=1.
  - FORB: q=0, qn=0.
  - UNK: q != qn.
- Oscillation:
  - Toggle counter increments on each change of q while {s,r} is unchanged. It clears on a {s,r} change.
  - When it reaches OSC_LIMIT, osc is set and stays set until clear or rst_n.
- Counters saturate at all-ones and never wrap.
  - forbid_cnt increments on each transition into FORB.
  - race_cnt increments on each race pulse.
  - mismatch_cnt increments on each 0->1 edge of mismatch.
- clear=1:
  - Next edge zeroes all counters and osc.
  - Does not alter state, the synchronisers or the settle counter.
  - Any increment event in the same cycle is dropped.
- Simultaneous events: a race pulse and a mismatch edge in the same cycle both count.
- Reset mid-operation: everything returns to reset values immediately. After release, outputs are unchecked until SYNC_STAGES+SETTLE cycles have passed.

Decomposition:
- Shared package sr_pkg:
  - state enum/localparams ST_UNK=0, ST_SET=1, ST_RST=2, ST_FORB=3.
  - Function for the per-state check.
- One natural sub-module: sync_ff (SYNC_STAGES-deep, reset-to-0 synchroniser), instantiated four times.
- Saturating counters stay inline.

Test Plan:
- Reset then S=0,R=1 with latch model Q=0,Qn=1 -> 3 cycles later state=RST; after SETTLE, mismatch=0 and all counters 0.
- S=1,R=1 with Q=Qn=0, then S=0,R=0 -> state=FORB and forbid_cnt=1; then race pulses for 1 cycle, state=UNK, race_cnt=1.
- Stimulus sequence 01,11,10,11,00,11 at 5-cycle spacing -> states RST,FORB,SET,FORB,UNK(race),FORB; forbid_cnt=3, race_cnt=1.
- State SET but Q forced 0, Qn 1 -> mismatch rises SETTLE cycles after S/R stable; mismatch_cnt=1. Fix Q -> mismatch falls, count stays 1.
- S=R=0 in UNK, Q toggling every cycle -> osc=1 after 4 toggles; clear pulse -> osc=0 and counters 0.
- Force 300 forbidden entries with CNT_W=8 -> forbid_cnt=255 (saturated); assert rst_n mid-sequence -> all outputs 0 and state=UNK immediately.

Source files
------------

// File: rtl/sr_latch_monitor_pkg.sv
// Shared types for the SR latch monitor: expected-state encoding and the
// per-state output check.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_UNK  = 2'd0,
    ST_SET  = 2'd1,
    ST_RST  = 2'd2,
    ST_FORB = 2'd3
  } sr_state_e;

  // NOR latch outputs that are legal for each expected state.
  function automatic logic outputs_ok(input sr_state_e st, input logic q, input logic qn);
    logic ok;
    case (st)
      ST_SET:  ok = q & ~qn;
      ST_RST:  ok = ~q & qn;
      ST_FORB: ok = ~q & ~qn;
      default: ok = q ^ qn;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sr_latch_monitor_sync_ff.sv
// Reset-to-zero multi-flop synchroniser for one asynchronous bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/sr_latch_monitor.sv
// Clocked observer of a NOR SR latch: tracks expected state, flags forbidden
// input, release races, output mismatches and oscillation, with event counters.
//
// state   | meaning
// UNK     | latch content unknown (reset or after 11->00 release)
// SET     | last non-zero S/R was 10, Q expected 1
// RST     | last non-zero S/R was 01, Q expected 0
// FORB    | S=R=1, both outputs expected 0
module sr_latch_monitor
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2,
  parameter int OSC_LIMIT   = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             r_in,
  input  logic             q_in,
  input  logic             qn_in,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             expected_q,
  output logic             forbidden,
  output logic             race,
  output logic             mismatch,
  output logic             osc,
  output logic [CNT_W-1:0] forbid_cnt,
  output logic [CNT_W-1:0] race_cnt,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  logic s, r, q, qn;
  logic [1:0] sr_prev;
  logic sr_changed;
  logic [WARM_W-1:0] warm_cnt;
  logic [3:0] settle_cnt;
  logic [3:0] tog_cnt;
  logic q_prev;
  logic check_en, toggle, forbid_evt, mm_rise, mismatch_q;
  sr_state_e st_q, st_d;
  logic race_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_s  (.clk(clk), .rst_n(rst_n), .d(s_in),  .q(s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_r  (.clk(clk), .rst_n(rst_n), .d(r_in),  .q(r));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_q  (.clk(clk), .rst_n(rst_n), .d(q_in),  .q(q));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_qn (.clk(clk), .rst_n(rst_n), .d(qn_in), .q(qn));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_UNK;
      race <= 1'b0;
    end else begin
      st_q <= st_d;
      race <= race_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    race_d = 1'b0;
    case ({s, r})
      2'b10:   st_d = ST_SET;
      2'b01:   st_d = ST_RST;
      2'b11:   st_d = ST_FORB;
      default: begin
        if (st_q == ST_FORB) begin
          st_d   = ST_UNK;
          race_d = 1'b1;
        end
      end
    endcase
  end

  assign sr_changed = ({s, r} != sr_prev);
  // Inputs that move in the same cycle as S/R are compared against the old
  // state for one cycle, so a visible S/R change also disables the check.
  assign check_en   = (settle_cnt == 4'(SETTLE)) && !sr_changed;
  assign mismatch   = check_en && !outputs_ok(st_q, q, qn);
  assign toggle     = (warm_cnt == '0) && !sr_changed && (q != q_prev)
                      && (tog_cnt != 4'(OSC_LIMIT));
  assign forbid_evt = (st_d == ST_FORB) && (st_q != ST_FORB);
  assign mm_rise    = mismatch && !mismatch_q;

  assign state      = st_q;
  assign expected_q = (st_q == ST_SET);
  assign forbidden  = (st_q == ST_FORB);

  // warm_cnt covers the synchroniser fill after reset so settle starts late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_prev    <= 2'b00;
      warm_cnt   <= WARM_W'(SYNC_STAGES);
      settle_cnt <= '0;
      tog_cnt    <= '0;
      q_prev     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      sr_prev    <= {s, r};
      q_prev     <= q;
      mismatch_q <= mismatch;
      if (warm_cnt != '0) warm_cnt <= warm_cnt - WARM_W'(1);
      if (warm_cnt != '0 || sr_changed)       settle_cnt <= '0;
      else if (settle_cnt != 4'(SETTLE))      settle_cnt <= settle_cnt + 4'd1;
      if (sr_changed)  tog_cnt <= '0;
      else if (toggle) tog_cnt <= tog_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc          <= 1'b0;
      forbid_cnt   <= '0;
      race_cnt     <= '0;
      mismatch_cnt <= '0;
    end else if (clear) begin
      osc          <= 1'b0;
      forbid_cnt   <= '0;
      race_cnt     <= '0;
      mismatch_cnt <= '0;
    end else begin
      if (toggle && tog_cnt == 4'(OSC_LIMIT - 1)) osc <= 1'b1;
      if (forbid_evt && forbid_cnt != '1)   forbid_cnt   <= forbid_cnt + CNT_W'(1);
      if (race_d && race_cnt != '1)         race_cnt     <= race_cnt + CNT_W'(1);
      if (mm_rise && mismatch_cnt != '1)    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Directed bench for sr_latch_monitor: vector table for the state walk plus
// hand sequences for race, mismatch, oscillation, saturation and reset.
module tb_sr_latch_monitor;

  logic clk = 1'b0;
  logic rst_n, s_in, r_in, q_in, qn_in, clear;
  logic [1:0] state;
  logic expected_q, forbidden, race, mismatch, osc;
  logic [7:0] forbid_cnt, race_cnt, mismatch_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic s, r, q, qn;
    int   st;
    int   mm;
    int   fc;
    int   rc;
  } vec_t;

  vec_t vecs[6];

  sr_latch_monitor #(.SYNC_STAGES(2), .SETTLE(2), .OSC_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .r_in(r_in), .q_in(q_in), .qn_in(qn_in),
    .clear(clear), .state(state), .expected_q(expected_q), .forbidden(forbidden),
    .race(race), .mismatch(mismatch), .osc(osc), .forbid_cnt(forbid_cnt),
    .race_cnt(race_cnt), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic q, input logic qn);
    s_in = s; r_in = r; q_in = q; qn_in = qn;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{s:1'b0, r:1'b1, q:1'b0, qn:1'b1, st:2, mm:0, fc:0, rc:0};
    vecs[1] = '{s:1'b1, r:1'b1, q:1'b0, qn:1'b0, st:3, mm:0, fc:1, rc:0};
    vecs[2] = '{s:1'b1, r:1'b0, q:1'b1, qn:1'b0, st:1, mm:0, fc:1, rc:0};
    vecs[3] = '{s:1'b1, r:1'b1, q:1'b0, qn:1'b0, st:3, mm:0, fc:2, rc:0};
    vecs[4] = '{s:1'b0, r:1'b0, q:1'b1, qn:1'b0, st:0, mm:0, fc:2, rc:1};
    vecs[5] = '{s:1'b1, r:1'b1, q:1'b0, qn:1'b0, st:3, mm:0, fc:3, rc:1};

    rst_n = 1'b0; clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    chk("reset_state", int'(state), 0);
    chk("reset_race", int'(race), 0);
    chk("reset_osc", int'(osc), 0);
    chk("reset_fcnt", int'(forbid_cnt), 0);

    // Reset release into RST
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(3);
    chk("rst_state", int'(state), 2);
    step(2);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_fcnt", int'(forbid_cnt), 0);
    chk("rst_rcnt", int'(race_cnt), 0);
    chk("rst_mcnt", int'(mismatch_cnt), 0);

    // Forbidden entry then release race
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step(5);
    chk("forb_state", int'(state), 3);
    chk("forb_level", int'(forbidden), 1);
    chk("forb_fcnt", int'(forbid_cnt), 1);
    chk("forb_mismatch", int'(mismatch), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    chk("race_pre", int'(race), 0);
    chk("race_pre_state", int'(state), 3);
    step(1);
    chk("race_pulse", int'(race), 1);
    chk("race_state", int'(state), 0);
    chk("race_rcnt", int'(race_cnt), 1);
    step(1);
    chk("race_end", int'(race), 0);

    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_fcnt", int'(forbid_cnt), 0);
    chk("clr_rcnt", int'(race_cnt), 0);
    chk("clr_state_kept", int'(state), 0);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].s, vecs[i].r, vecs[i].q, vecs[i].qn);
      step(5);
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      chk($sformatf("vec%0d_expq", i), int'(expected_q), (vecs[i].st == 1) ? 1 : 0);
      chk($sformatf("vec%0d_forb", i), int'(forbidden), (vecs[i].st == 3) ? 1 : 0);
      chk($sformatf("vec%0d_mm", i), int'(mismatch), vecs[i].mm);
      chk($sformatf("vec%0d_fcnt", i), int'(forbid_cnt), vecs[i].fc);
      chk($sformatf("vec%0d_rcnt", i), int'(race_cnt), vecs[i].rc);
    end

    // SET with wrong outputs
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    chk("mm_state", int'(state), 1);
    chk("mm_unsettled0", int'(mismatch), 0);
    step(1);
    chk("mm_unsettled1", int'(mismatch), 0);
    step(1);
    chk("mm_rise", int'(mismatch), 1);
    chk("mm_cnt_lag", int'(mismatch_cnt), 0);
    step(1);
    chk("mm_cnt1", int'(mismatch_cnt), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step(2);
    chk("mm_fall", int'(mismatch), 0);
    step(2);
    chk("mm_cnt_hold", int'(mismatch_cnt), 1);

    // Oscillation in UNK
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step(5);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step(5);
    chk("osc_unk", int'(state), 0);
    chk("osc_rcnt", int'(race_cnt), 2);
    for (int i = 0; i < 3; i++) begin
      q_in = ~q_in; qn_in = ~qn_in;
      step(1);
    end
    step(4);
    chk("osc_3tog", int'(osc), 0);
    chk("osc_nomm", int'(mismatch), 0);
    q_in = ~q_in; qn_in = ~qn_in;
    step(4);
    chk("osc_set", int'(osc), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("osc_clr", int'(osc), 0);
    chk("osc_clr_fcnt", int'(forbid_cnt), 0);
    chk("osc_clr_rcnt", int'(race_cnt), 0);
    chk("osc_clr_mcnt", int'(mismatch_cnt), 0);
    step(2);
    chk("osc_stay_clr", int'(osc), 0);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      step(2);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      step(2);
    end
    step(5);
    chk("sat_fcnt", int'(forbid_cnt), 255);
    chk("sat_rcnt", int'(race_cnt), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step(4);
    chk("sat_forb", int'(state), 3);
    rst_n = 1'b0;
    #2;
    chk("arst_state", int'(state), 0);
    chk("arst_forb", int'(forbidden), 0);
    chk("arst_fcnt", int'(forbid_cnt), 0);
    chk("arst_expq", int'(expected_q), 0);
    chk("arst_mm", int'(mismatch), 0);

    // Post-reset check blanking with illegal UNK outputs
    step(1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    step(3);
    chk("warm_blank", int'(mismatch), 0);
    step(1);
    chk("warm_check", int'(mismatch), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
